// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of any depth >= 2, with occupancy count, programmable almost flags,
// a read-valid strobe, synchronous flush and sticky overflow/underflow error flags.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 12,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         o_rd_valid,
    output logic                         o_fifo_full,
    output logic                         o_fifo_empty,
    output logic                         o_almost_full,
    output logic                         o_almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_mem_we;
    logic [CW-1:0]         w_count_nxt;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);
    assign w_mem_we = w_wr_acc & ~rst & ~i_flush;

    always_comb begin
        // NOTE: default assignment first so no path leaves w_count_nxt unassigned (no latch).
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: storage has no reset; its contents are don't-care until written, and leaving
    // it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so the read below sees the
    // word stored before this edge even when a write hits the same slot (full + both ops).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= ptr_inc(r_rd_ptr);
            end
            r_rd_valid <= w_rd_acc;
            r_count    <= w_count_nxt;
            if (wr_en & ~w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en & ~w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rd_data        = r_rd_data;
    assign o_rd_valid     = r_rd_valid;
    assign o_fifo_full    = w_full;
    assign o_fifo_empty   = w_empty;
    assign o_almost_full  = (r_count >= AF_CNT);
    assign o_almost_empty = (r_count <= AE_CNT);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: queue-based reference model with a read-data scoreboard,
// a table of fill/drain vectors, and hand-written boundary sequences.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          o_rd_valid;
    logic          o_fifo_full;
    logic          o_fifo_empty;
    logic          o_almost_full;
    logic          o_almost_empty;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_underflow;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .o_rd_valid    (o_rd_valid),
        .o_fifo_full   (o_fifo_full),
        .o_fifo_empty  (o_fifo_empty),
        .o_almost_full (o_almost_full),
        .o_almost_empty(o_almost_empty),
        .o_count       (o_count),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

    typedef struct {
        logic          wr;
        logic [DW-1:0] d;
        logic          rd;
        logic [CW-1:0] exp_count;
        logic [4:0]    exp_flags;   // {full, empty, rd_valid, overflow, underflow}
    } vec_t;

    int            n_pass = 0;
    int            n_total = 0;
    logic [DW-1:0] mq[$];           // model contents
    logic [DW-1:0] sb[$];           // words expected on the read port, in order
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        logic [DW-1:0] exp_word;
        sz = mq.size();
        check({tag, ":count"}, 32'(o_count), sz);
        check({tag, ":full"}, 32'(o_fifo_full), 32'(sz == DEPTH));
        check({tag, ":empty"}, 32'(o_fifo_empty), 32'(sz == 0));
        check({tag, ":afull"}, 32'(o_almost_full), 32'(sz >= AF));
        check({tag, ":aempty"}, 32'(o_almost_empty), 32'(sz <= AE));
        check({tag, ":rd_valid"}, 32'(o_rd_valid), 32'(m_valid));
        check({tag, ":overflow"}, 32'(o_overflow), 32'(m_ovf));
        check({tag, ":underflow"}, 32'(o_underflow), 32'(m_unf));
        check({tag, ":rd_data"}, 32'(rd_data), 32'(m_rd));
        if (o_rd_valid) begin
            check({tag, ":sb_has_word"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_word = sb.pop_front();
                check({tag, ":sb_word"}, 32'(rd_data), 32'(exp_word));
            end
        end
    endtask

    // One clock of stimulus; the model decides acceptance from the pre-edge state.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic fl, input string tag);
        bit rd_ok;
        bit wr_ok;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        i_flush = fl;
        if (fl) begin
            mq.delete();
            sb.delete();
            m_rd    = '0;
            m_valid = 1'b0;
        end else begin
            rd_ok = rd && (mq.size() > 0);
            wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                m_rd = mq.pop_front();
                sb.push_back(m_rd);
            end
            if (wr_ok) mq.push_back(d);
            if (wr && !wr_ok) m_ovf = 1'b1;
            if (rd && !rd_ok) m_unf = 1'b1;
            m_valid = rd_ok;
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    // Requests are held high during reset to show they are ignored.
    task automatic do_reset(input int cycles, input string tag);
        rst     = 1'b1;
        i_flush = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'hFF;
        mq.delete();
        sb.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_rd    = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_state($sformatf("%s%0d", tag, i));
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    function automatic vec_t mk(input logic wr, input logic [DW-1:0] d, input logic rd,
                                input logic [CW-1:0] c, input logic [4:0] f);
        vec_t v;
        v.wr        = wr;
        v.d         = d;
        v.rd        = rd;
        v.exp_count = c;
        v.exp_flags = f;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        vecs[0]  = mk(1'b1, 8'h34, 1'b0, 4'd1, 5'b00000);
        vecs[1]  = mk(1'b1, 8'hA8, 1'b0, 4'd2, 5'b00000);
        vecs[2]  = mk(1'b1, 8'h0F, 1'b0, 4'd3, 5'b00000);
        vecs[3]  = mk(1'b1, 8'hAB, 1'b0, 4'd4, 5'b00000);
        vecs[4]  = mk(1'b1, 8'h09, 1'b0, 4'd5, 5'b00000);
        vecs[5]  = mk(1'b0, 8'h00, 1'b1, 4'd4, 5'b00100);
        vecs[6]  = mk(1'b0, 8'h00, 1'b1, 4'd3, 5'b00100);
        vecs[7]  = mk(1'b0, 8'h00, 1'b1, 4'd2, 5'b00100);
        vecs[8]  = mk(1'b0, 8'h00, 1'b1, 4'd1, 5'b00100);
        vecs[9]  = mk(1'b0, 8'h00, 1'b1, 4'd0, 5'b01100);
        vecs[10] = mk(1'b1, 8'h55, 1'b1, 4'd1, 5'b00001);  // both at empty: read rejected
        vecs[11] = mk(1'b0, 8'h00, 1'b1, 4'd0, 5'b01101);
        vecs[12] = mk(1'b0, 8'h00, 1'b0, 4'd0, 5'b01001);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 4'd0, 5'b01001);

        // Reset and idle
        do_reset(3, "reset");
        step(1'b0, 8'h00, 1'b0, 1'b0, "idle");
        check("idle:rd_data_zero", 32'(rd_data), 32'h0);

        // Fill/drain and empty-boundary vectors
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].wr, vecs[i].d, vecs[i].rd, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d:tbl_count", i), 32'(o_count), 32'(vecs[i].exp_count));
            check($sformatf("tbl%0d:tbl_flags", i),
                  32'({o_fifo_full, o_fifo_empty, o_rd_valid, o_overflow, o_underflow}),
                  32'(vecs[i].exp_flags));
        end

        // Overfill: 13 writes, the last dropped
        do_reset(1, "rst_ovf");
        for (int i = 1; i <= 13; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, $sformatf("ovf_wr%0d", i));
        end
        check("ovf:count_12", 32'(o_count), 32'd12);
        check("ovf:full", 32'(o_fifo_full), 32'd1);
        check("ovf:sticky", 32'(o_overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("ovf_rd%0d", i));
        end
        check("ovf:last_word_0c", 32'(rd_data), 32'h0C);
        check("ovf:empty_after_drain", 32'(o_fifo_empty), 32'd1);

        // Simultaneous read and write at full
        do_reset(1, "rst_full");
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, $sformatf("full_wr%0d", i));
        end
        step(1'b1, 8'hEE, 1'b1, 1'b0, "full_both");
        check("full_both:count", 32'(o_count), 32'd12);
        check("full_both:no_overflow", 32'(o_overflow), 32'd0);
        check("full_both:oldest", 32'(rd_data), 32'h01);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("full_rd%0d", i));
        end
        check("full_both:ee_last", 32'(rd_data), 32'hEE);

        // Continuous streaming through pointer wrap
        do_reset(1, "rst_wrap");
        step(1'b1, 8'h00, 1'b0, 1'b0, "wrap_pre");
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, $sformatf("wrap%0d", i));
        end
        check("wrap:last_out", 32'(rd_data), 32'd29);
        step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
        check("wrap:final_word", 32'(rd_data), 32'd30);

        // Flush keeps error flags; reset clears them
        do_reset(1, "rst_flush");
        for (int i = 1; i <= 13; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, $sformatf("fl_wr%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("fl_rd%0d", i));
        end
        check("flush:pre_count_7", 32'(o_count), 32'd7);
        step(1'b1, 8'hAA, 1'b1, 1'b1, "flush");
        check("flush:count_0", 32'(o_count), 32'd0);
        check("flush:overflow_kept", 32'(o_overflow), 32'd1);
        check("flush:rd_data_0", 32'(rd_data), 32'h0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, "post_flush_wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_flush_rd");
        check("post_flush:word", 32'(rd_data), 32'h5A);
        do_reset(1, "rst_final");
        check("final_reset:overflow_clear", 32'(o_overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
